// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and access-size decode for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: merges store bytes into a two-word window and extracts/extends load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] words,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [63:0] merged,
  output logic [31:0] load
);
  logic [63:0] mask;
  logic [31:0] sh;
  logic [5:0]  bits;
  assign bits   = {1'b0, off, 3'b000};
  assign mask   = size == 3'd4 ? 64'hFFFF_FFFF : size == 3'd2 ? 64'hFFFF : 64'hFF;
  assign merged = (words & ~(mask << bits)) | (({32'b0, wdata} & mask) << bits);
  assign sh     = 32'(words >> bits);
  assign load   = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                  funct3 == F3_BU ? {24'b0, sh[7:0]} :
                  funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                  funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns RV32I byte/half/word loads and stores into word-only memory accesses
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);
  state_t state, nxt;
  logic [31:0] a_addr, a_wdata, w0, w1, base, load;
  logic [2:0]  a_f3, size, in_size;
  logic        a_we, a_err, span, in_span, in_err;
  logic [63:0] merged;
  assign size    = size_of(a_f3);
  assign span    = ({2'b0, a_addr[1:0]} + {1'b0, size}) > 4'd4;
  assign base    = {a_addr[31:2], 2'b00};
  assign in_size = size_of(funct3);
  assign in_span = ({2'b0, addr[1:0]} + {1'b0, in_size}) > 4'd4;
  assign in_err  = funct3 == 3'b011 || (funct3[2] && funct3[1]) || (we && funct3[2]) ||
                   (in_span && !ALLOW_MISALIGNED);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req) nxt = in_err ? RESP : (we && funct3 == F3_W && addr[1:0] == 2'b00) ? WR0 : RD0;
      RD0:  nxt = span ? RD1 : a_we ? WR0 : RESP;
      RD1:  nxt = a_we ? WR0 : RESP;
      WR0:  nxt = span ? WR1 : RESP;
      WR1:  nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  // The word read this cycle feeds extraction directly so rdata lands on entry to RESP.
  lsu_align u_align (
    .words ({state == RD1 ? mem_RD : w1, state == RD0 ? mem_RD : w0}),
    .off   (a_addr[1:0]),
    .size  (size),
    .wdata (a_wdata),
    .funct3(a_f3),
    .merged(merged),
    .load  (load)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_addr <= '0; a_wdata <= '0; a_f3 <= '0; a_we <= 1'b0; a_err <= 1'b0;
      w0 <= '0; w1 <= '0; rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        a_addr <= addr; a_wdata <= wdata; a_f3 <= funct3; a_we <= we; a_err <= in_err;
      end
      if (state == RD0) w0 <= mem_RD;
      if (state == RD1) w1 <= mem_RD;
      if (nxt == RESP && (state == RD0 || state == RD1) && !a_we) rdata <= load;
    end
  always_comb begin
    busy   = state != IDLE;
    done   = state == RESP;
    err    = done && a_err;
    mem_WE = state == WR0 || state == WR1;
    mem_A  = (state == RD0 || state == WR0) ? base :
             (state == RD1 || state == WR1) ? base + 32'd4 : '0;
    mem_WD = state == WR0 ? merged[31:0] : state == WR1 ? merged[63:32] : '0;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-only data memory. That memory is 32-bit, byte-addressed, word-aligned, with combinational read and a posedge write when WE is high.
- Converts RV32I lb/lh/lw/lbu/lhu/sb/sh/sw requests into word accesses. Sub-word stores use read-modify-write.
- Accesses that cross a word boundary are split into two word transactions, sequenced by an FSM with a req/done handshake.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two word accesses; 0 = flag them as errors with no memory access.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte or halfword used for sb/sh.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; illegal funct3 or disallowed misalignment.
- rdata  out  32  load result, extended; held until the next done.
- mem_A  out  32  word address to data memory (low 2 bits always 00).
- mem_WD  out  32  write word to data memory.
- mem_WE  out  1  write enable to data memory.
- mem_RD  in  32  combinational read word from data memory.

Behaviour:
- Reset values: busy 0, done 0, err 0, rdata 0, mem_WE 0, mem_A 0, mem_WD 0; state IDLE; all latched registers 0.
- Request latch: in IDLE with req=1, latch addr, we, funct3 and wdata.
- Derived values from the latched request:
  - off = addr[1:0]
  - size = 1/2/4 bytes
  - base = {addr[31:2], 2'b00}
  - span = (off + size > 4)
- Illegal requests go IDLE -> RESP with err=1 and no memory access:
  - funct3 in {011, 110, 111};
  - we=1 with funct3 100 or 101;
  - span with ALLOW_MISALIGNED=0.
- States and transitions:
  - IDLE: aligned sw goes to WR0; every other legal request goes to RD0.
  - RD0: mem_A = base; latch w0 = mem_RD. Next: RD1 if span, else WR0 if we, else RESP.
  - RD1: mem_A = base + 4 (modulo 2^32, so 0xFFFFFFFC wraps to 0); latch w1. Next: WR0 if we, else RESP.
  - WR0: mem_A = base, mem_WD = merged low word, mem_WE = 1. Next: WR1 if span, else RESP.
  - WR1: mem_A = base + 4, mem_WD = merged high word, mem_WE = 1. Next: RESP.
  - RESP: done = 1 for exactly one cycle; rdata updated on entry (loads only; stores and errors leave rdata unchanged). Next: IDLE.
- Memory outputs are decoded combinationally from the state and latched registers. mem_WE is 1 only in WR0/WR1; mem_A and mem_WD are 0 in IDLE and RESP.
- Merge rule: the 64-bit {w1, w0} has the bytes off .. off+size-1 replaced by the low bytes of wdata (little-endian). For an aligned sw, wdata is written as-is.
- Load extraction: ({w1, w0} >> 8*off) truncated to size. Sign-extend for b/h/w; zero-extend for bu/hu.
- Latency, counted as done asserting N cycles after the cycle req is accepted:
  - aligned load 2;
  - aligned sw 2;
  - sub-word store 3;
  - spanning load 3;
  - spanning store 5;
  - error 1.
- req while busy is ignored and never queued. The next req is accepted no earlier than the cycle after done.
- Reset mid-operation: state returns to IDLE and mem_WE drops asynchronously. A spanning store interrupted after WR0 leaves only the low word updated; this is accepted behaviour.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE, RD0, RD1, WR0, WR1, RESP), and a size-decode function.
- Sub-module lsu_align, combinational:
  - inputs {w1, w0}, off, size, wdata, funct3;
  - outputs the merged 64-bit write data and the extended load value.

Test Plan:
- Memory preload: 0x100 = 0x44332211, 0x104 = 0x88776655.
- lw 0x100 -> rdata 0x44332211; done 2 cycles after accept; mem_WE never asserted; err 0.
- lb 0x103 -> 0x00000044; lb 0x107 -> 0xFFFFFF88; lbu 0x107 -> 0x00000088; lhu 0x106 -> 0x00008877.
- sh 0x102 with wdata 0xAAAABEEF -> word 0x100 = 0xBEEF2211; exactly one mem_WE cycle; done at cycle 3.
- Spanning accesses:
  - lw 0x103 -> 0x77665544 with two reads (0x100, 0x104) and done at cycle 3;
  - then sw 0x103 with 0xDDCCBBAA -> 0x100 = 0xAA332211, 0x104 = 0x88DDCCBB; two consecutive WE cycles.
- Error cases, each with no memory access:
  - funct3 = 011 -> done with err = 1 one cycle after accept;
  - with ALLOW_MISALIGNED = 0, lw 0x101 -> err = 1;
  - a req pulsed while busy is ignored.
- Assert rst during WR0 of a spanning store -> mem_WE falls in the same cycle; busy, done, err and rdata are 0; word 0x104 is unchanged; the next lw completes normally.
